// File: rtl/pc_redirect_unit.sv
// PC register and control-flow redirect stage: resolves branch/JAL/JALR targets,
// sequences redirects against the imem handshake, and keeps branch statistics.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             branch_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misaligned_fault,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, PENDING} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  logic        req, mis;
  logic [31:0] tgt_raw, tgt_eff;

  always_comb begin
    req     = (ex_branch & branch_taken) | ex_jal | ex_jalr;
    tgt_raw = ex_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    mis     = tgt_raw[1:0] != 2'b00;
    tgt_eff = mis ? TRAP_VECTOR : tgt_raw;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    fault_d     = 1'b0;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch && bcnt_q != '1) bcnt_d = bcnt_q + CNT_ONE;
        if (ex_branch && branch_taken && tcnt_q != '1) tcnt_d = tcnt_q + CNT_ONE;
        if (req) begin
          fault_d     = mis;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (imem_ready) begin
            pc_d = tgt_eff;
          end else begin
            pend_d  = tgt_eff;
            state_d = PENDING;
          end
        end else if (!stall && imem_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PENDING: begin
        // EX holds bubbles here; only the imem handshake matters
        if (imem_ready) begin
          pc_d        = pend_q;
          state_d     = RUN;
          flush_if_id = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h0;
      fault_q <= 1'b0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign misaligned_fault = fault_q;
  assign branch_cnt       = bcnt_q;
  assign taken_cnt        = tcnt_q;

endmodule
